wb_select_stage: RTL and testbench

- Parametrised write-back stage for the multicycle MIPS datapath.
- Selects one of NUM_SRC result sources: ALU result, memory data register, PC+4 link, LUI immediate.
- Applies load byte/halfword extraction and sign/zero extension to memory data.
- Registers the result toward the register file behind a valid/ready handshake. Suppresses writes to $zero and counts committed write-backs.

---
 rtl/mips_wb_pkg.sv | 15 +
 rtl/load_extend.sv | 52 +++++
 rtl/wb_select_stage.sv | 100 ++++++++++
 tb/tb_wb_select_stage.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_wb_pkg.sv
// Shared constants for the MIPS write-back stage: load formats and result-source indices.
package mips_wb_pkg;

  localparam logic [2:0] LD_W  = 3'b000;
  localparam logic [2:0] LD_B  = 3'b001;
  localparam logic [2:0] LD_BU = 3'b010;
  localparam logic [2:0] LD_H  = 3'b011;
  localparam logic [2:0] LD_HU = 3'b100;

  localparam int SRC_ALU  = 0;
  localparam int SRC_MEM  = 1;
  localparam int SRC_LINK = 2;
  localparam int SRC_IMM  = 3;

endpackage

// File: rtl/load_extend.sv
// Combinational load formatter: byte/halfword lane extraction with sign or zero extension.
// Flags halfword loads whose byte offset is odd.
module load_extend
  import mips_wb_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0]            i_data,
  input  logic [2:0]                   i_ld_mode,
  input  logic [$clog2(DATA_W/8)-1:0]  i_byte_off,
  output logic [DATA_W-1:0]            o_data,
  output logic                         o_misaligned
);

  localparam int NB = DATA_W / 8;
  localparam int NH = DATA_W / 16;
  localparam int BW = $clog2(NB);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [BW-1:0] w_half_idx;

  assign w_half_idx = i_byte_off >> 1;

  always_comb begin
    w_byte = i_data[7:0];
    for (int k = 0; k < NB; k++) begin
      if (i_byte_off == BW'(k)) w_byte = i_data[k*8 +: 8];
    end
  end

  always_comb begin
    w_half = i_data[15:0];
    for (int k = 0; k < NH; k++) begin
      if (w_half_idx == BW'(k)) w_half = i_data[k*16 +: 16];
    end
  end

  always_comb begin
    o_data = i_data;
    case (i_ld_mode)
      LD_B:    o_data = {{(DATA_W-8){w_byte[7]}}, w_byte};
      LD_BU:   o_data = {{(DATA_W-8){1'b0}}, w_byte};
      LD_H:    o_data = {{(DATA_W-16){w_half[15]}}, w_half};
      LD_HU:   o_data = {{(DATA_W-16){1'b0}}, w_half};
      default: o_data = i_data;
    endcase
  end

  assign o_misaligned = ((i_ld_mode == LD_H) || (i_ld_mode == LD_HU)) && i_byte_off[0];

endmodule

// File: rtl/wb_select_stage.sv
// Write-back stage: source mux + load formatting into a one-entry output register, 1-cycle latency.
// Valid/ready output; in_ready = !out_valid || out_ready so a draining entry is replaced with no bubble.
module wb_select_stage
  import mips_wb_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int NUM_SRC = 4,
  parameter int REG_AW  = 5,
  parameter int CNT_W   = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [NUM_SRC*DATA_W-1:0]     src_data,
  input  logic [$clog2(NUM_SRC)-1:0]    wb_sel,
  input  logic [2:0]                    ld_mode,
  input  logic [$clog2(DATA_W/8)-1:0]   byte_off,
  input  logic [REG_AW-1:0]             dest_reg,
  input  logic                          reg_write,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [REG_AW-1:0]             out_reg,
  output logic [DATA_W-1:0]             out_data,
  output logic                          misalign_err,
  output logic [CNT_W-1:0]              wb_count
);

  localparam int SW = $clog2(NUM_SRC);

  logic              r_valid;
  logic [REG_AW-1:0] r_reg;
  logic [DATA_W-1:0] r_data;
  logic              r_misalign;
  logic [CNT_W-1:0]  r_count;

  logic [DATA_W-1:0] w_src;
  logic [DATA_W-1:0] w_ext;
  logic              w_ext_mis;
  logic              w_is_mem;
  logic [DATA_W-1:0] w_fmt;
  logic              w_misalign;
  logic              w_accept;
  logic              w_drain;
  logic              w_write;

  // Out-of-range selects never match a loop index, so they fall back to source 0.
  always_comb begin
    w_src = src_data[DATA_W-1:0];
    for (int k = 1; k < NUM_SRC; k++) begin
      if (wb_sel == SW'(k)) w_src = src_data[k*DATA_W +: DATA_W];
    end
  end

  load_extend #(
    .DATA_W (DATA_W)
  ) u_load_extend (
    .i_data       (src_data[SRC_MEM*DATA_W +: DATA_W]),
    .i_ld_mode    (ld_mode),
    .i_byte_off   (byte_off),
    .o_data       (w_ext),
    .o_misaligned (w_ext_mis)
  );

  assign w_is_mem   = (wb_sel == SW'(SRC_MEM));
  assign w_fmt      = w_is_mem ? w_ext : w_src;
  assign w_misalign = w_is_mem && w_ext_mis;

  assign in_ready = !r_valid || out_ready;
  assign w_accept = in_valid && in_ready;
  assign w_drain  = r_valid && out_ready;
  assign w_write  = w_accept && reg_write && (dest_reg != '0) && !w_misalign;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid    <= 1'b0;
      r_reg      <= '0;
      r_data     <= '0;
      r_misalign <= 1'b0;
      r_count    <= '0;
    end else begin
      if (w_write) begin
        r_valid <= 1'b1;
        r_reg   <= dest_reg;
        r_data  <= w_fmt;
      end else if (w_drain) begin
        r_valid <= 1'b0;
      end
      r_misalign <= w_accept && w_misalign;
      if (w_drain) r_count <= r_count + CNT_W'(1);
    end
  end

  assign out_valid    = r_valid;
  assign out_reg      = r_reg;
  assign out_data     = r_data;
  assign misalign_err = r_misalign;
  assign wb_count     = r_count;

endmodule

// File: tb/tb_wb_select_stage.sv
// Bench for wb_select_stage: vector table + scoreboard on the default instance, wrap/out-of-range
// select on a second instance with NUM_SRC=5, CNT_W=4.
module tb_wb_select_stage;
  import mips_wb_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Default instance
  logic         in_valid, in_ready, out_valid, out_ready, reg_write, misalign_err;
  logic [127:0] src_data;
  logic [1:0]   wb_sel, byte_off;
  logic [2:0]   ld_mode;
  logic [4:0]   dest_reg, out_reg;
  logic [31:0]  out_data;
  logic [15:0]  wb_count;

  wb_select_stage u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .src_data(src_data), .wb_sel(wb_sel), .ld_mode(ld_mode), .byte_off(byte_off),
    .dest_reg(dest_reg), .reg_write(reg_write), .out_valid(out_valid),
    .out_ready(out_ready), .out_reg(out_reg), .out_data(out_data),
    .misalign_err(misalign_err), .wb_count(wb_count)
  );

  // Second instance: five sources (3-bit select) and a 4-bit counter
  logic         in_valid2, in_ready2, out_valid2, misalign_err2;
  logic [159:0] src_data2;
  logic [2:0]   wb_sel2;
  logic [4:0]   dest_reg2, out_reg2;
  logic [31:0]  out_data2;
  logic [3:0]   wb_count2;

  wb_select_stage #(.DATA_W(32), .NUM_SRC(5), .REG_AW(5), .CNT_W(4)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .src_data(src_data2), .wb_sel(wb_sel2), .ld_mode(LD_W), .byte_off(2'd0),
    .dest_reg(dest_reg2), .reg_write(1'b1), .out_valid(out_valid2),
    .out_ready(1'b1), .out_reg(out_reg2), .out_data(out_data2),
    .misalign_err(misalign_err2), .wb_count(wb_count2)
  );

  int n_cmp = 0;
  int n_err = 0;
  int exp_cnt = 0;
  logic [36:0] sb[$];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard: every completed handshake must match the oldest expected write
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_write", {27'd0, out_reg, out_data}, 64'd0);
      end else begin
        logic [36:0] e;
        e = sb.pop_front();
        check("sb_reg", 64'(out_reg), 64'(e[36:32]));
        check("sb_data", 64'(out_data), 64'(e[31:0]));
      end
    end
  end

  typedef struct {
    logic [1:0]  sel;
    logic [2:0]  mode;
    logic [1:0]  off;
    logic [4:0]  dest;
    logic        rw;
    logic        exp_wr;
    logic [31:0] exp_data;
    logic        exp_mis;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs[NV];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{2'd0, LD_W,  2'd0, 5'd8,  1'b1, 1'b1, 32'h0000_1234, 1'b0};
    vecs[1]  = '{2'd1, LD_W,  2'd0, 5'd3,  1'b1, 1'b1, 32'h80FF_7F01, 1'b0};
    vecs[2]  = '{2'd1, LD_B,  2'd2, 5'd3,  1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0};
    vecs[3]  = '{2'd1, LD_BU, 2'd2, 5'd4,  1'b1, 1'b1, 32'h0000_00FF, 1'b0};
    vecs[4]  = '{2'd1, LD_H,  2'd2, 5'd5,  1'b1, 1'b1, 32'hFFFF_80FF, 1'b0};
    vecs[5]  = '{2'd1, LD_HU, 2'd2, 5'd6,  1'b1, 1'b1, 32'h0000_80FF, 1'b0};
    vecs[6]  = '{2'd1, LD_B,  2'd0, 5'd7,  1'b1, 1'b1, 32'h0000_0001, 1'b0};
    vecs[7]  = '{2'd1, LD_B,  2'd1, 5'd10, 1'b1, 1'b1, 32'h0000_007F, 1'b0};
    vecs[8]  = '{2'd1, LD_B,  2'd3, 5'd11, 1'b1, 1'b1, 32'hFFFF_FF80, 1'b0};
    vecs[9]  = '{2'd1, LD_H,  2'd0, 5'd12, 1'b1, 1'b1, 32'h0000_7F01, 1'b0};
    vecs[10] = '{2'd1, 3'd5,  2'd2, 5'd13, 1'b1, 1'b1, 32'h80FF_7F01, 1'b0};
    vecs[11] = '{2'd2, LD_W,  2'd0, 5'd31, 1'b1, 1'b1, 32'h0040_0008, 1'b0};
    vecs[12] = '{2'd3, LD_W,  2'd0, 5'd14, 1'b1, 1'b1, 32'h5678_0000, 1'b0};
    vecs[13] = '{2'd1, LD_H,  2'd1, 5'd9,  1'b1, 1'b0, 32'h0,         1'b1};
    vecs[14] = '{2'd1, LD_HU, 2'd3, 5'd9,  1'b0, 1'b0, 32'h0,         1'b1};
    vecs[15] = '{2'd0, LD_W,  2'd0, 5'd0,  1'b1, 1'b0, 32'h0,         1'b0};
    vecs[16] = '{2'd0, LD_W,  2'd0, 5'd4,  1'b0, 1'b0, 32'h0,         1'b0};
    vecs[17] = '{2'd0, LD_H,  2'd1, 5'd15, 1'b1, 1'b1, 32'h0000_1234, 1'b0};

    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b1; reg_write = 1'b0;
    src_data = {32'h5678_0000, 32'h0040_0008, 32'h80FF_7F01, 32'h0000_1234};
    wb_sel = '0; ld_mode = LD_W; byte_off = '0; dest_reg = '0;
    in_valid2 = 1'b0; src_data2 = '0; wb_sel2 = '0; dest_reg2 = '0;

    #3;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_reg", 64'(out_reg), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_misalign", 64'(misalign_err), 64'd0);
    check("rst_wb_count", 64'(wb_count), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    #10 rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(posedge clk); #1;
      wb_sel = vecs[i].sel; ld_mode = vecs[i].mode; byte_off = vecs[i].off;
      dest_reg = vecs[i].dest; reg_write = vecs[i].rw; in_valid = 1'b1;
      if (vecs[i].exp_wr) begin
        sb.push_back({vecs[i].dest, vecs[i].exp_data});
        exp_cnt++;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      check($sformatf("v%0d_misalign", i), 64'(misalign_err), 64'(vecs[i].exp_mis));
      check($sformatf("v%0d_out_valid", i), 64'(out_valid), 64'(vecs[i].exp_wr));
      @(posedge clk); #1;
      check($sformatf("v%0d_wb_count", i), 64'(wb_count), 64'(exp_cnt));
      check($sformatf("v%0d_misalign_end", i), 64'(misalign_err), 64'd0);
    end

    // Back-pressure: hold A for 3 cycles while B waits, then drain A and load B at one edge
    @(posedge clk); #1;
    out_ready = 1'b0; wb_sel = 2'd0; ld_mode = LD_W; reg_write = 1'b1;
    src_data[31:0] = 32'h0000_1111; dest_reg = 5'd5; in_valid = 1'b1;
    sb.push_back({5'd5, 32'h0000_1111}); exp_cnt++;
    @(posedge clk); #1;
    src_data[31:0] = 32'h0000_2222; dest_reg = 5'd6;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("bp%0d_in_ready", c), 64'(in_ready), 64'd0);
      check($sformatf("bp%0d_out_valid", c), 64'(out_valid), 64'd1);
      check($sformatf("bp%0d_out_reg", c), 64'(out_reg), 64'd5);
      check($sformatf("bp%0d_out_data", c), 64'(out_data), 64'h1111);
      @(posedge clk); #1;
    end
    check("bp_count_held", 64'(wb_count), 64'(exp_cnt - 1));
    out_ready = 1'b1;
    sb.push_back({5'd6, 32'h0000_2222}); exp_cnt++;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_no_bubble_valid", 64'(out_valid), 64'd1);
    check("bp_no_bubble_reg", 64'(out_reg), 64'd6);
    check("bp_count_a", 64'(wb_count), 64'(exp_cnt - 1));
    @(posedge clk); #1;
    check("bp_count_b", 64'(wb_count), 64'(exp_cnt));
    check("bp_drained", 64'(out_valid), 64'd0);

    // Reset mid-write: held entry is discarded without a clock edge
    out_ready = 1'b0; src_data[31:0] = 32'h0000_3333; dest_reg = 5'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("mr_held", 64'(out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mr_out_valid", 64'(out_valid), 64'd0);
    check("mr_wb_count", 64'(wb_count), 64'd0);
    check("mr_out_data", 64'(out_data), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("mr_in_ready", 64'(in_ready), 64'd1);
    exp_cnt = 0;
    out_ready = 1'b1;

    // Second instance: out-of-range selects fall back to source 0; 17 commits wrap a 4-bit counter
    for (int i = 0; i < 17; i++) begin
      logic [31:0] exp_d;
      @(posedge clk); #1;
      wb_sel2 = (i % 3 == 0) ? 3'd5 : ((i % 3 == 1) ? 3'd7 : 3'd4);
      src_data2 = '0;
      src_data2[31:0]   = 32'hA0A0_0000 + 32'(i);
      src_data2[63:32]  = 32'hDEAD_0001;
      src_data2[159:128] = 32'h4444_0000 + 32'(i);
      dest_reg2 = 5'(1 + i);
      in_valid2 = 1'b1;
      exp_d = (i % 3 == 2) ? (32'h4444_0000 + 32'(i)) : (32'hA0A0_0000 + 32'(i));
      @(posedge clk); #1;
      in_valid2 = 1'b0;
      @(negedge clk);
      check($sformatf("d2_%0d_valid", i), 64'(out_valid2), 64'd1);
      check($sformatf("d2_%0d_data", i), 64'(out_data2), 64'(exp_d));
      check($sformatf("d2_%0d_count", i), 64'(wb_count2), 64'(i % 16));
    end
    @(posedge clk); #1;
    check("d2_count_wrap", 64'(wb_count2), 64'd1);

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
